// File: rtl/ahb_ram_slave_ctrl.sv
// AHB-Lite slave front end for the word-addressed data RAM.
// Registers the address phase, drives RAM strobes in the data phase, and inserts the read wait state.
module ahb_ram_slave_ctrl #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        sel_1,
    output logic        rd_en_ram,
    output logic        wr_en_ram,
    output logic [31:0] wr_data,
    output logic [31:0] address_ram,
    input  logic [31:0] rd_data
);

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             valid;
    logic             addr_err;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    assign idx      = haddr[IDX_W+1:2];
    assign valid    = hsel & hready_in & htrans[1];
    assign addr_err = (hsize != SIZE_WORD) | (haddr[1:0] != 2'b00) | (32'(idx) >= 32'(DEPTH));

    // Upper address bits alias onto the RAM; htrans[0] only separates NONSEQ from SEQ.
    assign unused_addr_bits = ^{haddr[31:IDX_W+2], htrans[0]};

    // Next state: wait states run to completion, every other state may accept a new transfer.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_RD_REQ: state_nxt = S_RD_DATA;
            S_ERR1:   state_nxt = S_ERR2;
            default: begin
                if (valid) begin
                    if (addr_err)    state_nxt = S_ERR1;
                    else if (hwrite) state_nxt = S_WR;
                    else             state_nxt = S_RD_REQ;
                end
            end
        endcase
    end

    // State and registered response/strobe outputs, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            hreadyout   <= 1'b1;
            hresp       <= 1'b0;
            sel_1       <= 1'b0;
            rd_en_ram   <= 1'b0;
            wr_en_ram   <= 1'b0;
            address_ram <= '0;
        end else begin
            state     <= state_nxt;
            hreadyout <= !((state_nxt == S_RD_REQ) || (state_nxt == S_ERR1));
            hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
            sel_1     <= (state_nxt == S_RD_REQ) || (state_nxt == S_WR);
            rd_en_ram <= (state_nxt == S_RD_REQ);
            wr_en_ram <= (state_nxt == S_WR);
            if ((state_nxt == S_RD_REQ) || (state_nxt == S_WR))
                address_ram <= 32'(idx);
        end
    end

    // Write data and read data belong to the data phase itself, so they pass straight through.
    assign wr_data = (state == S_WR)      ? hwdata  : '0;
    assign hrdata  = (state == S_RD_DATA) ? rd_data : '0;

endmodule

// File: tb/tb_ahb_ram_slave_ctrl.sv
// Scoreboard bench for ahb_ram_slave_ctrl: randomized AHB traffic against a simple memory model.
module tb_ahb_ram_slave_ctrl;

    localparam int unsigned DEPTH = 5;
    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] idx;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sel_1;
    logic        rd_en_ram;
    logic        wr_en_ram;
    logic [31:0] wr_data;
    logic [31:0] address_ram;
    logic [31:0] rd_data;

    logic [31:0] ram     [DEPTH];
    logic [31:0] mem_ref [DEPTH];
    exp_t        exp_q   [$];
    int          phase;
    int          checks = 0;
    int          errors = 0;

    ahb_ram_slave_ctrl #(.DEPTH(DEPTH), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .hsel       (hsel),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hready_in  (hreadyout),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .sel_1      (sel_1),
        .rd_en_ram  (rd_en_ram),
        .wr_en_ram  (wr_en_ram),
        .wr_data    (wr_data),
        .address_ram(address_ram),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Data RAM with a registered read port.
    always @(posedge clk) begin
        if (wr_en_ram && sel_1 && address_ram < DEPTH) ram[address_ram] <= wr_data;
        if (rd_en_ram && address_ram < DEPTH) rd_data <= ram[address_ram];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet_bus();
        chk("idle_hreadyout", hreadyout, 1);
        chk("idle_hresp", hresp, 0);
        chk("idle_hrdata", hrdata, 0);
        chk("idle_rd_en", rd_en_ram, 0);
        chk("idle_wr_en", wr_en_ram, 0);
        chk("idle_sel", sel_1, 0);
    endtask

    // Monitor: compare each data-phase cycle against the head of the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            phase = 0;
            chk_quiet_bus();
            chk("rst_address_ram", address_ram, 0);
            chk("rst_wr_data", wr_data, 0);
        end else if (exp_q.size() == 0) begin
            phase = 0;
            chk_quiet_bus();
        end else begin
            exp_t e;
            e = exp_q[0];
            phase++;
            if (e.kind == K_WR) begin
                chk("wr_hreadyout", hreadyout, 1);
                chk("wr_hresp", hresp, 0);
                chk("wr_en", wr_en_ram, 1);
                chk("wr_rd_en", rd_en_ram, 0);
                chk("wr_sel", sel_1, 1);
                chk("wr_addr", address_ram, e.idx);
                chk("wr_data", wr_data, e.data);
                chk("wr_hrdata", hrdata, 0);
                void'(exp_q.pop_front());
                phase = 0;
            end else if (e.kind == K_RD) begin
                if (phase == 1) begin
                    chk("rdreq_hreadyout", hreadyout, 0);
                    chk("rdreq_hresp", hresp, 0);
                    chk("rdreq_rd_en", rd_en_ram, 1);
                    chk("rdreq_wr_en", wr_en_ram, 0);
                    chk("rdreq_sel", sel_1, 1);
                    chk("rdreq_addr", address_ram, e.idx);
                    chk("rdreq_hrdata", hrdata, 0);
                end else begin
                    chk("rddata_hreadyout", hreadyout, 1);
                    chk("rddata_hresp", hresp, 0);
                    chk("rddata_rd_en", rd_en_ram, 0);
                    chk("rddata_wr_en", wr_en_ram, 0);
                    chk("rddata_sel", sel_1, 0);
                    chk("rddata_hrdata", hrdata, e.data);
                    void'(exp_q.pop_front());
                    phase = 0;
                end
            end else begin
                chk("err_hresp", hresp, 1);
                chk("err_hreadyout", hreadyout, (phase == 1) ? 0 : 1);
                chk("err_rd_en", rd_en_ram, 0);
                chk("err_wr_en", wr_en_ram, 0);
                chk("err_sel", sel_1, 0);
                chk("err_hrdata", hrdata, 0);
                if (phase != 1) begin
                    void'(exp_q.pop_front());
                    phase = 0;
                end
            end
        end
    end

    // Present one address phase, hold it until the bus is ready, then record the expected response.
    task automatic issue(input logic s, input logic [1:0] t, input logic w,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic rdy;
        int   n;
        exp_t e;
        hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a;
        n = 0;
        do begin
            @(negedge clk);
            rdy = hreadyout;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 8);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: hreadyout stuck low for %0d cycles", n);
        end
        hwdata = $urandom;
        if (s && t[1]) begin
            e.idx  = 32'((a >> 2) & 32'h7);
            e.data = 32'h0;
            if (sz != 3'b010 || a[1:0] != 2'b00 || e.idx >= DEPTH) begin
                e.kind = K_ERR;
            end else if (w) begin
                e.kind  = K_WR;
                e.data  = d;
                hwdata  = d;
                mem_ref[e.idx] = d;
            end else begin
                e.kind = K_RD;
                e.data = mem_ref[e.idx];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_slots(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] init_vals [DEPTH];
        init_vals = '{32'hA0A0_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_EEEE};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = init_vals[i];
            mem_ref[i] = init_vals[i];
        end
        reset = 1'b1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = '0; hwdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b1, 2'b10, 1'b1, 3'b010, 32'h08, 32'h1234_5678);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h08, 32'h0);
        issue(1'b1, 2'b10, 1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
        issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h01, 32'h0);
        issue(1'b1, 2'b01, 1'b1, 3'b010, 32'h04, 32'hBAD0_0001);
        issue(1'b0, 2'b10, 1'b1, 3'b010, 32'h04, 32'hBAD0_0002);
        issue(1'b1, 2'b11, 1'b0, 3'b010, 32'h04, 32'h0);
        idle_slots(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic [2:0]  sz;
            logic [31:0] a;
            s  = ($urandom_range(0, 9) != 0);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            a  = {20'($urandom), 7'h0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(s, 2'($urandom), 1'($urandom), sz, a, $urandom);
        end
        idle_slots(3);

        // Reset asserted while the read wait state is in progress
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0C, 32'h0);
        hsel = 1'b0; htrans = 2'b00;
        #2;
        chk("pre_reset_rd_en", rd_en_ram, 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_hreadyout", hreadyout, 1);
        chk("async_rst_rd_en", rd_en_ram, 0);
        chk("async_rst_sel", sel_1, 0);
        chk("async_rst_hresp", hresp, 0);
        chk("async_rst_hrdata", hrdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_slots(2);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0C, 32'h0);
        idle_slots(3);

        for (int i = 0; i < DEPTH; i++) chk($sformatf("ram_final_%0d", i), ram[i], mem_ref[i]);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
